gpio_wb_multi: RTL and testbench
================================

Name: gpio_wb_multi

Overview:
- Parametrised Wishbone-slave GPIO bank with WIDTH channels. Successor to the single-bit trigger GPIO.
- Per-pin features: output data, direction, synchronised input readback, atomic set/clear and edge-detect interrupts.
- Sits on the SoC peripheral Wishbone bus. Drives board pins, testbench triggers and status LEDs, and feeds one interrupt line to the core.

Parameters:
- WIDTH, 8, number of GPIO channels (1..32); register bits above WIDTH read 0 and ignore writes.
- ADDR_LSB, 2, lowest decoded address bit; adr[ADDR_LSB+2:ADDR_LSB] selects the register.
- DEBOUNCE_CYCLES, 16, stable-input cycles required when GPIO_DEBOUNCE_EN is defined (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error (unmapped register)
- wb_stall_o  out  1  always 0
- wb_dat_o  out  32  read data
- gpio_i  in  WIDTH  asynchronous pin inputs
- gpio_o  out  WIDTH  pin output values
- gpio_oe_o  out  WIDTH  output enables, 1 = drive
- irq_o  out  1  level interrupt

Behaviour:
- Reset: gpio_o=0, gpio_oe_o=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0. All registers and synchroniser/edge state are 0.
- Register map (index = adr[ADDR_LSB+2:ADDR_LSB]):
  - 0 OUT: RW
  - 1 DIR: RW
  - 2 IN: RO, synchronised pins
  - 3 SET: WO, OUT |= data
  - 4 CLR: WO, OUT &= ~data
  - 5 IRQ_EN: RW
  - 6 IRQ_POL: RW, 1=rising, 0=falling
  - 7 IRQ_STAT: read / write-1-to-clear
- WO registers read 0.
- Handshake: a request is cyc&stb. wb_ack_o pulses high exactly one cycle after each request (registered, single-cycle latency).
  - wb_dat_o is valid in the ack cycle and 0 otherwise.
  - Back-to-back requests on consecutive cycles get back-to-back acks; the bus is pipelined with no stall.
- The write side effect is applied on the same clock edge that asserts ack.
- Byte selects: sel[n] gates bits [8n+7:8n] for OUT, DIR, IRQ_EN, IRQ_POL, SET, CLR and IRQ_STAT writes.
- Writes to IN: ignored, acked, no error.
- wb_err_o: reserved for unmapped indices. All 8 indices are mapped at ADDR_LSB=2, so err stays 0. It is asserted in place of ack only if a future revision leaves holes.
- gpio_o = OUT and gpio_oe_o = DIR, registered outputs. A write shows on the pins in the ack cycle.
- Input path: 2-flop synchroniser per bit, then an edge register (previous value).
  - Rising edge = sync & ~prev. Falling edge = ~sync & prev.
  - IRQ_STAT[i] sets when the edge matching IRQ_POL[i] occurs, regardless of IRQ_EN.
  - Latency: a pin change sampled at edge k is readable in IN after edge k+1. IRQ_STAT sets at edge k+2.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins, the bit stays 1.
- irq_o = registered OR of (IRQ_STAT & IRQ_EN). It rises one cycle after the status bit sets. It drops one cycle after the last enabled bit clears or its enable is cleared.
- Input pins are sampled regardless of DIR, so output pins loop back into IN.
- Reset asserted mid-transaction: all state is cleared immediately. A pending ack is dropped and not re-issued.

Optional Feature:
- GPIO_DEBOUNCE_EN defined: each synchronised bit passes through a per-bit counter.
  - The filtered value updates only after DEBOUNCE_CYCLES consecutive cycles at a value differing from the current filtered value.
  - The counter restarts on any glitch.
  - IN and edge detection use the filtered value, adding DEBOUNCE_CYCLES cycles of latency.
  - Filtered value and counters reset to 0.
- Undefined: no counters; IN and edges use the synchroniser output directly, timing as above.

Test Plan:
- Reset release, read all 8 indices -> data 0, gpio_o=0, gpio_oe_o=0, irq_o=0, each ack exactly 1 cycle after stb.
- Write OUT=0xA5 sel=4'b0001, then SET=0x0F, then CLR=0x81 -> gpio_o sequence 0xA5, 0xAF, 0x2E; read OUT=0x2E.
- Write OUT=0x1234 with sel=4'b0010 (WIDTH=16) -> OUT=0x1200; two back-to-back reads -> two consecutive ack cycles.
- IRQ_POL=0x01, IRQ_EN=0x01, gpio_i[0] 0->1 -> IRQ_STAT=0x01 after 2 edges, irq_o=1 one cycle later; W1C 0x01 -> irq_o=0.
- gpio_i[1] falls with POL[1]=0 and EN[1]=0 -> IRQ_STAT=0x02, irq_o stays 0. W1C issued in the same cycle as a new edge -> bit stays 1.
- GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: a 5-cycle pulse on gpio_i[2] -> IN unchanged. A 20-cycle high -> IN[2]=1 after 2+16 cycles.

Source files
------------

// File: rtl/gpio_wb_multi.sv
// Wishbone GPIO bank: OUT/DIR/IN, atomic SET/CLR, per-pin edge interrupts; GPIO_DEBOUNCE_EN adds input filtering.
// Latency: ack and read data one cycle after cyc&stb; writes land on the same edge that raises ack.
// Backpressure: none; stall is tied low and every request is acked in order.
module gpio_wb_multi #(
    parameter int WIDTH           = 8,
    parameter int ADDR_LSB        = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_stall_o,
    output logic [31:0]      wb_dat_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam logic [7:0] MAPPED = 8'hFF;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [2:0] IDX_OUT  = 3'd0;
    localparam logic [2:0] IDX_DIR  = 3'd1;
    localparam logic [2:0] IDX_IN   = 3'd2;
    localparam logic [2:0] IDX_SET  = 3'd3;
    localparam logic [2:0] IDX_CLR  = 3'd4;
    localparam logic [2:0] IDX_EN   = 3'd5;
    localparam logic [2:0] IDX_POL  = 3'd6;
    localparam logic [2:0] IDX_STAT = 3'd7;

    logic             w_req;
    logic             w_wr;
    logic             w_mapped;
    logic [2:0]       w_idx;
    logic [31:0]      w_bmask;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wdat;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_hit;
    logic [31:0]      w_rd;
    logic             w_unused;

    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_dat;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_en;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic             r_irq;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_idx    = wb_adr_i[ADDR_LSB+2:ADDR_LSB];
    assign w_mapped = MAPPED[w_idx];
    assign w_wr     = w_req & wb_we_i & w_mapped;
    assign w_bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_wmask  = w_bmask[WIDTH-1:0];
    assign w_wdat   = wb_dat_i[WIDTH-1:0] & w_wmask;
    assign w_w1c    = (w_wr && w_idx == IDX_STAT) ? w_wdat : '0;
    assign w_unused = &{1'b0, wb_adr_i, wb_dat_i, w_bmask};

    always_comb begin
        w_rd = '0;
        case (w_idx)
            IDX_OUT:  w_rd[WIDTH-1:0] = r_out;
            IDX_DIR:  w_rd[WIDTH-1:0] = r_dir;
            IDX_IN:   w_rd[WIDTH-1:0] = w_filt;
            IDX_EN:   w_rd[WIDTH-1:0] = r_en;
            IDX_POL:  w_rd[WIDTH-1:0] = r_pol;
            IDX_STAT: w_rd[WIDTH-1:0] = r_stat;
            default:  w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & w_mapped;
            r_err <= w_req & ~w_mapped;
            r_dat <= (w_req && !wb_we_i && w_mapped) ? w_rd : '0;
        end
    end

    // Writes to IN and unlisted indices fall through the default and are only acked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
            r_dir <= '0;
            r_en  <= '0;
            r_pol <= '0;
        end else if (w_wr) begin
            case (w_idx)
                IDX_OUT: r_out <= (r_out & ~w_wmask) | w_wdat;
                IDX_DIR: r_dir <= (r_dir & ~w_wmask) | w_wdat;
                IDX_SET: r_out <= r_out | w_wdat;
                IDX_CLR: r_out <= r_out & ~w_wdat;
                IDX_EN:  r_en  <= (r_en & ~w_wmask) | w_wdat;
                IDX_POL: r_pol <= (r_pol & ~w_wmask) | w_wdat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
            r_prev  <= w_filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [WIDTH-1:0] r_filt;
    logic [CW-1:0]    r_cnt [WIDTH];

    // Count only while the input disagrees with the filtered value; any return resets the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    assign w_rise = w_filt & ~r_prev;
    assign w_fall = ~w_filt & r_prev;
    assign w_hit  = (w_rise & r_pol) | (w_fall & ~r_pol);

    // A new edge overrides a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_w1c) | w_hit;
            r_irq  <= |(r_stat & r_en);
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign wb_stall_o = 1'b0;
    assign wb_dat_o   = r_dat;
    assign gpio_o     = r_out;
    assign gpio_oe_o  = r_dir;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_gpio_wb_multi.sv
// Directed bench for gpio_wb_multi (WIDTH=16, default build): register map, byte selects,
// pipelined acks, edge interrupts with W1C/set priority, and mid-transaction reset.
module tb_gpio_wb_multi;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [31:0]      adr;
    logic [31:0]      dat_wr;
    logic [3:0]       sel;
    logic             ack;
    logic             err;
    logic             stall;
    logic [31:0]      dat_rd;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int n_pass  = 0;
    int n_total = 0;

    gpio_wb_multi #(.WIDTH(WIDTH), .ADDR_LSB(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_wr),
        .wb_sel_i   (sel),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_stall_o (stall),
        .wb_dat_o   (dat_rd),
        .gpio_i     (gpio_in),
        .gpio_o     (gpio_out),
        .gpio_oe_o  (gpio_oe),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One request driven at the falling edge; ack and data sampled 1ns after the next rising edge.
    task automatic wb(input logic w, input logic [2:0] idx, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, idx, 2'b00}; dat_wr = d; sel = s;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack", {31'd0, ack}, 32'd1);
        chk("err", {31'd0, err}, 32'd0);
        rd = dat_rd;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        wb(1'b1, idx, d, s, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] rd;
        wb(1'b0, idx, 32'd0, 4'hF, rd);
        chk(tag, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_wr = '0; sel = '0; gpio_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpio_o", 32'(gpio_out), 32'd0);
        chk("rst_oe", 32'(gpio_oe), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_rd, 32'd0);
        chk("stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("rd_idx%0d", i), 3'(i), 32'd0);
            @(posedge clk);
            #1;
            chk("ack_single", {31'd0, ack}, 32'd0);
            chk("dat_idle", dat_rd, 32'd0);
        end

        wr(3'd0, 32'h0000_00A5, 4'b0001);
        chk("out_a5", 32'(gpio_out), 32'h00A5);
        wr(3'd3, 32'h0000_000F, 4'hF);
        chk("set_0f", 32'(gpio_out), 32'h00AF);
        wr(3'd4, 32'h0000_0081, 4'hF);
        chk("clr_81", 32'(gpio_out), 32'h002E);
        rd_chk("rd_out_2e", 3'd0, 32'h0000_002E);

        wr(3'd0, 32'h0, 4'hF);
        wr(3'd0, 32'h0000_1234, 4'b0010);
        chk("out_sel1", 32'(gpio_out), 32'h1200);
        wr(3'd1, 32'hFFFF_0F0F, 4'hF);
        chk("dir_wide", 32'(gpio_oe), 32'h0F0F);
        wr(3'd2, 32'h0000_FFFF, 4'hF);
        rd_chk("in_ro", 3'd2, 32'h0);
        wr(3'd3, 32'h0000_0001, 4'h0);
        chk("set_nosel", 32'(gpio_out), 32'h1200);

        // back-to-back reads
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        adr = 32'h4;
        chk("b2b_ack0", {31'd0, ack}, 32'd1);
        chk("b2b_dat0", dat_rd, 32'h1200);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_ack1", {31'd0, ack}, 32'd1);
        chk("b2b_dat1", dat_rd, 32'h0F0F);
        @(posedge clk); #1;
        chk("b2b_ack2", {31'd0, ack}, 32'd0);
        chk("b2b_dat2", dat_rd, 32'h0);

        // rising edge on pin 0, enabled
        wr(3'd6, 32'h1, 4'hF);
        wr(3'd5, 32'h1, 4'hF);
        @(posedge clk); #1;
        gpio_in[0] = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        @(posedge clk); #1;
        chk("in_p1", dat_rd, 32'h0);
        @(posedge clk); #1;
        chk("in_p2", dat_rd, 32'h0);
        @(posedge clk); #1;
        chk("in_p3", dat_rd, 32'h1);
        chk("irq_p3", {31'd0, irq}, 32'd0);
        adr = 32'h1C;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        chk("stat_p4", dat_rd, 32'h1);
        chk("irq_p4", {31'd0, irq}, 32'd1);

        wr(3'd7, 32'h1, 4'hF);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        chk("irq_drop", {31'd0, irq}, 32'd0);
        rd_chk("stat_w1c", 3'd7, 32'h0);

        // pin 1 falling-edge sensitive, not enabled
        gpio_in[1] = 1'b1;
        repeat (4) @(posedge clk);
        rd_chk("stat_rise_ign", 3'd7, 32'h0);
        rd_chk("in_both", 3'd2, 32'h3);
        gpio_in[1] = 1'b0;
        repeat (4) @(posedge clk);
        rd_chk("stat_fall", 3'd7, 32'h2);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        gpio_in[1] = 1'b1;
        repeat (4) @(posedge clk);
        wr(3'd7, 32'h2, 4'hF);
        rd_chk("stat_clr1", 3'd7, 32'h0);
        gpio_in[1] = 1'b0;
        repeat (2) @(posedge clk);
        wr(3'd7, 32'h2, 4'hF);
        rd_chk("stat_setwins", 3'd7, 32'h2);
        chk("irq_masked2", {31'd0, irq}, 32'd0);

        // reset during a write's ack cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_wr = 32'hFFFF; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("pre_rst_out", 32'(gpio_out), 32'hFFFF);
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_out", 32'(gpio_out), 32'h0);
        chk("mid_rst_oe", 32'(gpio_oe), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", {31'd0, ack}, 32'd0);
        rd_chk("post_rst_out", 3'd0, 32'h0);
        rd_chk("post_rst_stat", 3'd7, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
